// File: rtl/adma_ram_arbiter_pkg.sv
// Shared types and constants for the ADMA system-RAM arbiter.
// Holds the sequencer state enum, address step and default widths.
package adma_ram_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;
  localparam int ADDR_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/adma_ram_arbiter_if.sv
// Requester and RAM bus bundles for the ADMA RAM arbiter.
// adma_req_if: burst request/response; adma_ram_if: single-port RAM.
interface adma_req_if
  import adma_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();
  logic              req;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              done;

  modport master (
    output req, start_addr, len, write, wdata,
    input  gnt, wready, rdata, rvalid, done
  );
  modport slave (
    input  req, start_addr, len, write, wdata,
    output gnt, wready, rdata, rvalid, done
  );
endinterface

interface adma_ram_if
  import adma_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [ADDR_W-1:0] ram_address;
  logic              ram_enable;
  logic              ram_write;
  logic [DATA_W-1:0] ram_data_out;
  logic [DATA_W-1:0] ram_data_in;

  modport master (
    output ram_address, ram_enable, ram_write, ram_data_out,
    input  ram_data_in
  );
  modport slave (
    input  ram_address, ram_enable, ram_write, ram_data_out,
    output ram_data_in
  );
endinterface

// File: rtl/adma_ram_burst_cnt.sv
// Burst address register (+4 per step, wrapping) and word down-counter.
// Ports: i_load latches i_addr/i_len, i_step advances, o_last = final word.
module adma_ram_burst_cnt
  import adma_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      // word aligned: byte offset bits are dropped
      r_addr <= i_addr & ~ADDR_W'(3);
      r_rem  <= i_len;
    end else if (i_step) begin
      r_addr <= r_addr + ADDR_W'(ADDR_STEP);
      r_rem  <= r_rem - LEN_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == LEN_W'(1));

endmodule

// File: rtl/adma_ram_arbiter.sv
// Two-requester round-robin burst arbiter/sequencer for the system RAM.
// Ports: CLK, RESET, io_rq0/io_rq1 (requesters), io_ram (RAM master).
module adma_ram_arbiter
  import adma_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  adma_req_if.slave   io_rq0,
  adma_req_if.slave   io_rq1,
  adma_ram_if.master  io_ram
);

  state_t            r_state;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_write;
  logic              r_rvalid;

  logic              w_any;
  logic              w_pick;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_busy;
  logic              w_wacc;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_start;
  logic [LEN_W-1:0]  w_len;
  logic              w_wr;
  logic [DATA_W-1:0] w_wdata;

  assign w_any  = io_rq0.req | io_rq1.req;
  // on a tie the requester that did not own the last burst wins
  assign w_pick = (io_rq0.req & io_rq1.req) ? ~r_last_owner
                                            : io_rq1.req;
  assign w_start = w_pick ? io_rq1.start_addr : io_rq0.start_addr;
  assign w_len   = w_pick ? io_rq1.len : io_rq0.len;
  assign w_wr    = w_pick ? io_rq1.write : io_rq0.write;
  assign w_load  = (r_state == IDLE) & w_any;
  assign w_step  = (r_state == XFER);

  adma_ram_burst_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_load (w_load),
    .i_step (w_step),
    .i_addr (w_start),
    .i_len  (w_len),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_write      <= 1'b0;
      r_rvalid     <= 1'b0;
    end else begin
      // RAM returns read data the cycle after the access
      r_rvalid <= (r_state == XFER) & ~r_write;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner      <= w_pick;
            r_last_owner <= w_pick;
            r_write      <= w_wr;
            r_state      <= (w_len == '0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (w_last)
            r_state <= r_write ? DONE : DRAIN;
        end
        DRAIN:   r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy  = (r_state != IDLE);
  assign w_wacc  = w_step & r_write;
  assign w_wdata = r_owner ? io_rq1.wdata : io_rq0.wdata;

  assign io_rq0.gnt    = w_busy & ~r_owner;
  assign io_rq1.gnt    = w_busy & r_owner;
  assign io_rq0.wready = w_wacc & ~r_owner;
  assign io_rq1.wready = w_wacc & r_owner;
  assign io_rq0.rvalid = r_rvalid & ~r_owner;
  assign io_rq1.rvalid = r_rvalid & r_owner;
  assign io_rq0.rdata  = io_rq0.rvalid ? io_ram.ram_data_in : '0;
  assign io_rq1.rdata  = io_rq1.rvalid ? io_ram.ram_data_in : '0;
  assign io_rq0.done   = (r_state == DONE) & ~r_owner;
  assign io_rq1.done   = (r_state == DONE) & r_owner;

  assign io_ram.ram_enable   = w_step;
  assign io_ram.ram_write    = w_wacc;
  assign io_ram.ram_address  = w_step ? w_addr : '0;
  assign io_ram.ram_data_out = w_wacc ? w_wdata : '0;

endmodule

// File: tb/tb_adma_ram_arbiter.sv
// Bench for adma_ram_arbiter: timeline model of each burst plus RAM.
// Directed scenarios followed by randomized two-requester traffic.
module tb_adma_ram_arbiter;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int VW = 8 + 3 * DW + AW + 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  adma_req_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) rq0 ();
  adma_req_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) rq1 ();
  adma_ram_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

  adma_ram_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .LEN_W  (LW)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .io_rq0 (rq0),
    .io_rq1 (rq1),
    .io_ram (ram)
  );

  logic [1:0]    req = '0;
  logic [1:0]    wr = '0;
  logic [AW-1:0] sa [2];
  logic [LW-1:0] ln [2];
  logic [DW-1:0] wd [2];

  assign rq0.req = req[0];
  assign rq1.req = req[1];
  assign rq0.write = wr[0];
  assign rq1.write = wr[1];
  assign rq0.start_addr = sa[0];
  assign rq1.start_addr = sa[1];
  assign rq0.len = ln[0];
  assign rq1.len = ln[1];
  assign rq0.wdata = wd[0];
  assign rq1.wdata = wd[1];

  wire [1:0] gnt  = {rq1.gnt, rq0.gnt};
  wire [1:0] wrdy = {rq1.wready, rq0.wready};
  wire [1:0] rv   = {rq1.rvalid, rq0.rvalid};
  wire [1:0] dn   = {rq1.done, rq0.done};

  // RAM with one-cycle read latency
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] ram_q = '0;
  assign ram.ram_data_in = ram_q;
  always @(posedge CLK) begin
    if (ram.ram_enable) begin
      if (ram.ram_write)
        mem[ram.ram_address] = ram.ram_data_out;
      else
        ram_q <= mem.exists(ram.ram_address) ?
                 mem[ram.ram_address] : '0;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  bit abort = 0;

  logic [AW-1:0] acc_q [$];
  logic [DW-1:0] rd_q [$];
  int            dn_q [$];

  // model: one active burst described by owner/base/len/dir/start cycle
  bit            chk_en = 0;
  bit            m_busy = 0;
  bit            m_own = 0;
  bit            m_last = 1;
  logic [AW-1:0] m_base;
  int            m_len;
  bit            m_wr;
  int            m_t0;
  logic [DW-1:0] m_mem [logic [AW-1:0]];

  always @(negedge CLK) begin : cmp
    int d, e;
    logic [1:0] e_gnt, e_wrdy, e_rv, e_dn;
    logic [DW-1:0] e_rd0, e_rd1, e_dout, v;
    logic [AW-1:0] e_addr, a;
    logic e_en, e_we;
    logic [VW-1:0] act, exp;
    e_gnt = '0; e_wrdy = '0; e_rv = '0; e_dn = '0;
    e_rd0 = '0; e_rd1 = '0; e_dout = '0; e_addr = '0;
    e_en = 0; e_we = 0; d = 0; e = 0;
    if (m_busy) begin
      d = cyc - m_t0;
      e = (m_wr || m_len == 0) ? m_len + 1 : m_len + 2;
      if (d >= 1 && d <= e) e_gnt[m_own] = 1'b1;
      if (d >= 1 && d <= m_len) begin
        e_en = 1;
        e_addr = m_base + AW'(4 * (d - 1));
        e_we = m_wr;
        if (m_wr) begin
          e_dout = wd[m_own];
          e_wrdy[m_own] = 1'b1;
        end
      end
      if (!m_wr && d >= 2 && d <= m_len + 1) begin
        e_rv[m_own] = 1'b1;
        a = m_base + AW'(4 * (d - 2));
        v = m_mem.exists(a) ? m_mem[a] : '0;
        if (m_own) e_rd1 = v;
        else e_rd0 = v;
      end
      if (d == e) e_dn[m_own] = 1'b1;
    end
    if (chk_en) begin
      nvec++;
      act = {gnt, wrdy, rv, dn, rq0.rdata, rq1.rdata,
             ram.ram_address, ram.ram_enable, ram.ram_write,
             ram.ram_data_out};
      exp = {e_gnt, e_wrdy, e_rv, e_dn, e_rd0, e_rd1,
             e_addr, e_en, e_we, e_dout};
      if (act !== exp) begin
        nerr++;
        $display("FAIL cyc%0d outputs: got gnt=%b wrdy=%b rv=%b dn=%b rd=%h/%h addr=%h en=%b we=%b dout=%h, required gnt=%b wrdy=%b rv=%b dn=%b rd=%h/%h addr=%h en=%b we=%b dout=%h",
                 cyc, gnt, wrdy, rv, dn, rq0.rdata, rq1.rdata,
                 ram.ram_address, ram.ram_enable, ram.ram_write,
                 ram.ram_data_out, e_gnt, e_wrdy, e_rv, e_dn,
                 e_rd0, e_rd1, e_addr, e_en, e_we, e_dout);
      end
      if (ram.ram_enable) acc_q.push_back(ram.ram_address);
      if (rv[0]) rd_q.push_back(rq0.rdata);
      if (rv[1]) rd_q.push_back(rq1.rdata);
      if (dn[0]) dn_q.push_back(0);
      if (dn[1]) dn_q.push_back(1);
    end
    if (m_busy && e_en && e_we) m_mem[e_addr] = wd[m_own];
    if (RESET) begin
      m_busy = 0;
      m_last = 1;
      chk_en = 1;
    end else if (m_busy) begin
      if (d == e) m_busy = 0;
    end else if (req[0] | req[1]) begin
      m_own  = (req[0] & req[1]) ? ~m_last : req[1];
      m_last = m_own;
      m_base = sa[m_own] & ~AW'(3);
      m_len  = int'(ln[m_own]);
      m_wr   = wr[m_own];
      m_t0   = cyc;
      m_busy = 1;
    end
  end

  task automatic check(input string nm, input logic [AW-1:0] got,
                       input logic [AW-1:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  // raise a request and hold it until done; lat<0 skips latency check
  task automatic run_burst(input int r, input logic [AW-1:0] a,
                           input int n, input bit w,
                           input logic [DW-1:0] wb, input int lat);
    int k, t, td;
    bit got;
    k = 0; got = 0; td = 0;
    sa[r] = a; ln[r] = LW'(n); wr[r] = w; wd[r] = wb;
    req[r] = 1'b1;
    t = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (wrdy[r]) k++;
      if (dn[r]) begin
        got = 1;
        td = cyc;
        break;
      end
      if (abort) break;
      @(posedge CLK);
      #1;
      wd[r] = wb + DW'(4 * k);
    end
    if (!got && !abort) begin
      nvec++;
      nerr++;
      $display("FAIL burst%0d timeout: no done in 400 cycles, required done", r);
    end
    if (got && lat >= 0) check($sformatf("lat%0d", r),
                               AW'(td - t), AW'(lat));
    @(posedge CLK);
    #1;
    req[r] = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 5) == 0)
      return 64'hFFFF_FFFF_FFFF_FFF0 | AW'($urandom_range(0, 15));
    return AW'($urandom_range(0, 255));
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      sa[i] = '0; ln[i] = '0; wd[i] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_gnt", AW'(gnt), 0);
    check("rst_en", AW'(ram.ram_enable), 0);
    @(posedge CLK);
    #1;

    // write burst
    acc_q.delete();
    run_burst(0, 64'd512, 24, 1, 32'd4, 25);
    check("wr_cnt", AW'(acc_q.size()), 24);
    if (acc_q.size() == 24) begin
      check("wr_a0", acc_q[0], 64'd512);
      check("wr_a23", acc_q[23], 64'd604);
    end

    // read back
    rd_q.delete();
    run_burst(1, 64'd512, 24, 0, 32'd0, 26);
    check("rd_cnt", AW'(rd_q.size()), 24);
    if (rd_q.size() == 24) begin
      check("rd_d0", AW'(rd_q[0]), 64'd4);
      check("rd_d23", AW'(rd_q[23]), 64'd96);
    end

    // tie twice: 0 then 1, alternating again
    for (int rep = 0; rep < 2; rep++) begin
      dn_q.delete();
      fork
        run_burst(0, 64'h1000, 3, 1, 32'd100, -1);
        run_burst(1, 64'h2000, 2, 0, 32'd0, -1);
      join
      check("tie_n", AW'(dn_q.size()), 2);
      if (dn_q.size() == 2) begin
        check("tie_1st", AW'(dn_q[0]), 0);
        check("tie_2nd", AW'(dn_q[1]), 1);
      end
    end

    // empty burst
    acc_q.delete();
    run_burst(0, 64'h300, 0, 1, 32'd0, 1);
    check("empty_acc", AW'(acc_q.size()), 0);

    // reset during the 10th access
    dn_q.delete();
    abort = 0;
    fork
      run_burst(0, 64'h800, 24, 1, 32'h100, -1);
      begin
        int n;
        n = 0;
        for (int i = 0; i < 100 && n < 9; i++) begin
          @(negedge CLK);
          if (ram.ram_enable) n++;
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        abort = 1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("ab_en", AW'(ram.ram_enable), 0);
        check("ab_gnt0", AW'(gnt[0]), 0);
        check("ab_wrdy0", AW'(wrdy[0]), 0);
      end
    join
    check("ab_nodone", AW'(dn_q.size()), 0);
    abort = 0;
    @(posedge CLK);
    #1;
    acc_q.delete();
    dn_q.delete();
    fork
      run_burst(0, 64'h4000, 2, 1, 32'd7, -1);
      run_burst(1, 64'h5000, 2, 0, 32'd0, -1);
    join
    if (acc_q.size() > 0) check("ab_restart", acc_q[0], 64'h4000);
    if (dn_q.size() > 0) check("ab_tie", AW'(dn_q[0]), 0);

    // alignment and wrap
    acc_q.delete();
    run_burst(0, 64'h203, 1, 1, 32'd9, 2);
    check("align", acc_q.size() > 0 ? acc_q[0] : '1, 64'h200);
    acc_q.delete();
    run_burst(1, 64'hFFFF_FFFF_FFFF_FFFC, 2, 1, 32'd11, 3);
    check("wrap_n", AW'(acc_q.size()), 2);
    if (acc_q.size() == 2) begin
      check("wrap_a0", acc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_a1", acc_q[1], 64'h0);
    end

    // random traffic
    for (int it = 0; it < 40; it++) begin
      fork
        begin
          if ($urandom_range(0, 9) < 7) begin
            repeat ($urandom_range(0, 3)) begin
              @(posedge CLK);
              #1;
            end
            run_burst(0, rnd_addr(), $urandom_range(0, 6),
                      1'($urandom_range(0, 1)), $urandom, -1);
          end
        end
        begin
          if ($urandom_range(0, 9) < 7) begin
            repeat ($urandom_range(0, 3)) begin
              @(posedge CLK);
              #1;
            end
            run_burst(1, rnd_addr(), $urandom_range(0, 6),
                      1'($urandom_range(0, 1)), $urandom, -1);
          end
        end
      join
      @(posedge CLK);
      #1;
    end

    repeat (3) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
